dds_gen: RTL and testbench

Parametrised direct digital synthesiser for the FM chain, succeeding the fixed-frequency sine DDS.
- Frequency word, phase offset, waveform mode and amplitude are runtime-configurable through a valid/ready port.
- Updates are optionally deferred to an accumulator wrap, so the output stays phase-continuous.
- Adds signed frequency modulation input, phase sync and wrap strobe.
- Feeds the modulator and DAC paths with a signed sample every sys_clk.

---
 rtl/dds_pkg.sv | 18 +
 rtl/dds_gen_sine_lut.sv | 30 +++
 rtl/dds_gen.sv | 183 ++++++++++++++++++
 tb/tb_dds_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types for the DDS generator: waveform modes, unity gain and the config FSM states.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } mode_t;

  localparam logic [7:0] AMP_UNITY = 8'd255;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_t;

endpackage

// File: rtl/dds_gen_sine_lut.sv
// Full-cycle sine table with a registered read; contents are computed at elaboration
// as round(peak * sin(2*pi*k/depth)), so no external init file is needed.
module sine_lut #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam int  DEPTH = 1 << ADDR_W;
  localparam real PI    = 3.14159265358979323846;
  localparam real PEAK  = $itor((1 << (DATA_W - 1)) - 1);

  logic [DATA_W-1:0] w_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real SCALED = PEAK * $sin(2.0 * PI * k / DEPTH);
    localparam int  VALUE  = $rtoi(SCALED >= 0.0 ? $floor(SCALED + 0.5) : -$floor(0.5 - SCALED));
    assign w_rom[k] = DATA_W'(VALUE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_data <= '0;
    else       o_data <= w_rom[i_addr];
  end

endmodule

// File: rtl/dds_gen.sv
// Runtime-configurable DDS: phase accumulator with FM and sync, wrap-aligned config
// commit, and a 3-stage waveform/amplitude pipeline.
module dds_gen
  import dds_pkg::*;
#(
  parameter int                 PHASE_W        = 32,
  parameter int                 ADDR_W         = 10,
  parameter int                 DATA_W         = 16,
  parameter int                 MOD_W          = 16,
  parameter int                 MOD_SHIFT      = 8,
  parameter logic [PHASE_W-1:0] FREQ_DEFAULT   = 32'd21474836,
  parameter int                 UPDATE_ON_WRAP = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [PHASE_W-1:0]       cfg_freq,
  input  logic [PHASE_W-1:0]       cfg_phase,
  input  logic [1:0]               cfg_mode,
  input  logic [7:0]               cfg_amp,
  input  logic                     mod_en,
  input  logic [MOD_W-1:0]         mod_in,
  input  logic                     sync_in,
  output logic signed [DATA_W-1:0] wave_out,
  output logic                     out_valid,
  output logic                     wrap_pulse
);

  localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] FULL_POS = {1'b0, {(DATA_W-1){1'b1}}};

  cfg_state_t         r_state, w_stateNext;
  logic [PHASE_W-1:0] r_acc, r_freq, r_phase, r_shFreq, r_shPhase;
  mode_t              r_mode, r_shMode;
  logic [7:0]         r_amp, r_shAmp;
  logic               w_latch, w_loadNow, w_commit;

  logic [PHASE_W-1:0] w_modExt, w_modTerm, w_step;
  logic [PHASE_W:0]   w_sum;
  logic               w_wrapEvent;

  assign w_modExt    = {{(PHASE_W-MOD_W){mod_in[MOD_W-1]}}, mod_in};
  assign w_modTerm   = mod_en ? (w_modExt << MOD_SHIFT) : '0;
  assign w_step      = r_freq + w_modTerm;
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_step};
  assign w_wrapEvent = w_sum[PHASE_W] | sync_in;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= CFG_IDLE;
    else         r_state <= w_stateNext;
  end

  // Wrap-aligned mode parks the request in the shadow set until the next wrap or sync.
  always_comb begin
    w_stateNext = r_state;
    cfg_ready   = 1'b0;
    w_latch     = 1'b0;
    w_loadNow   = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      CFG_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          w_latch = 1'b1;
          if (UPDATE_ON_WRAP != 0) w_stateNext = CFG_PENDING;
          else                     w_loadNow   = 1'b1;
        end
      end
      CFG_PENDING: begin
        if (w_wrapEvent) begin
          w_commit    = 1'b1;
          w_stateNext = CFG_IDLE;
        end
      end
      default: w_stateNext = CFG_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_freq    <= FREQ_DEFAULT;
      r_phase   <= '0;
      r_mode    <= MODE_SINE;
      r_amp     <= AMP_UNITY;
      r_shFreq  <= FREQ_DEFAULT;
      r_shPhase <= '0;
      r_shMode  <= MODE_SINE;
      r_shAmp   <= AMP_UNITY;
    end else begin
      if (w_latch) begin
        r_shFreq  <= cfg_freq;
        r_shPhase <= cfg_phase;
        r_shMode  <= mode_t'(cfg_mode);
        r_shAmp   <= cfg_amp;
      end
      if (w_loadNow) begin
        r_freq  <= cfg_freq;
        r_phase <= cfg_phase;
        r_mode  <= mode_t'(cfg_mode);
        r_amp   <= cfg_amp;
      end else if (w_commit) begin
        r_freq  <= r_shFreq;
        r_phase <= r_shPhase;
        r_mode  <= r_shMode;
        r_amp   <= r_shAmp;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_acc      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      r_acc      <= sync_in ? '0 : w_sum[PHASE_W-1:0];
      wrap_pulse <= w_wrapEvent;
    end
  end

  logic [ADDR_W-1:0] r_addr1;
  mode_t             r_mode1, r_mode2;
  logic [7:0]        r_amp1, r_amp2;
  logic              r_vld1, r_vld2;
  logic [DATA_W-1:0] w_shape, r_shape2, w_lutData, w_wave2;
  logic [ADDR_W-2:0] w_triF;
  logic [9:0]        w_gain;
  logic signed [DATA_W+9:0] w_prod;

  sine_lut #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sine_lut (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_addr (r_addr1),
    .o_data (w_lutData)
  );

  assign w_triF = r_addr1[ADDR_W-1] ? ~r_addr1[ADDR_W-2:0] : r_addr1[ADDR_W-2:0];

  always_comb begin
    w_shape = '0;
    case (r_mode1)
      MODE_SQUARE: w_shape = r_addr1[ADDR_W-1] ? -FULL_POS : FULL_POS;
      MODE_TRI:    w_shape = (DATA_W'(w_triF) << (DATA_W - ADDR_W + 1)) - SIGN_BIT;
      MODE_SAW:    w_shape = (DATA_W'(r_addr1) << (DATA_W - ADDR_W)) ^ SIGN_BIT;
      default:     w_shape = '0;
    endcase
  end

  assign w_wave2 = (r_mode2 == MODE_SINE) ? w_lutData : r_shape2;
  assign w_gain  = {2'b00, r_amp2} + 10'd1;
  assign w_prod  = $signed({{10{w_wave2[DATA_W-1]}}, w_wave2}) * $signed({{DATA_W{1'b0}}, w_gain});

  // Mode and amp travel with their phase so every sample uses one consistent config.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_addr1   <= '0;
      r_mode1   <= MODE_SINE;
      r_amp1    <= AMP_UNITY;
      r_vld1    <= 1'b0;
      r_shape2  <= '0;
      r_mode2   <= MODE_SINE;
      r_amp2    <= AMP_UNITY;
      r_vld2    <= 1'b0;
      wave_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      r_addr1   <= ADDR_W'((r_acc + r_phase) >> (PHASE_W - ADDR_W));
      r_mode1   <= r_mode;
      r_amp1    <= r_amp;
      r_vld1    <= 1'b1;
      r_shape2  <= w_shape;
      r_mode2   <= r_mode1;
      r_amp2    <= r_amp1;
      r_vld2    <= r_vld1;
      wave_out  <= DATA_W'(w_prod >>> 8);
      out_valid <= r_vld2;
    end
  end

endmodule

// File: tb/tb_dds_gen.sv
// Randomised bench for dds_gen: an immediate-update and a wrap-aligned instance share
// stimulus and are compared every cycle against an arithmetic model of the generator.
module tb_dds_gen;

  localparam real PI = 3.14159265358979323846;
  localparam longint TWO32 = 64'h1_0000_0000;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               cfg_valid = 1'b0;
  logic [31:0]        cfg_freq = '0;
  logic [31:0]        cfg_phase = '0;
  logic [1:0]         cfg_mode = '0;
  logic [7:0]         cfg_amp = '0;
  logic               mod_en = 1'b0;
  logic signed [15:0] mod_in = '0;
  logic               sync_in = 1'b0;

  logic               cfgReady [2];
  logic signed [15:0] waveOut [2];
  logic               outValid [2];
  logic               wrapPulse [2];

  int errCount = 0;
  int checkCount = 0;
  int cycle = 0;

  bit [31:0] mAcc [2], mFreq [2], mPhase [2], mShFreq [2], mShPhase [2];
  int        mMode [2], mAmp [2], mShMode [2], mShAmp [2];
  bit        mPending [2], mWrap [2];
  int        mPipe [2][3];
  int        mFill [2];

  always #10 sys_clk = ~sys_clk;

  dds_gen #(.UPDATE_ON_WRAP(0)) dutNow (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfgReady[0]),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode), .cfg_amp(cfg_amp),
    .mod_en(mod_en), .mod_in(mod_in), .sync_in(sync_in), .wave_out(waveOut[0]),
    .out_valid(outValid[0]), .wrap_pulse(wrapPulse[0])
  );

  dds_gen #(.UPDATE_ON_WRAP(1)) dutWrap (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfgReady[1]),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode), .cfg_amp(cfg_amp),
    .mod_en(mod_en), .mod_in(mod_in), .sync_in(sync_in), .wave_out(waveOut[1]),
    .out_valid(outValid[1]), .wrap_pulse(wrapPulse[1])
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int sineRef(input int a);
    real x;
    x = 32767.0 * $sin(2.0 * PI * a / 1024.0);
    return $rtoi(x >= 0.0 ? $floor(x + 0.5) : -$floor(0.5 - x));
  endfunction

  // Ideal sample for a given accumulator value and active configuration.
  function automatic int sampleOf(input bit [31:0] acc, input bit [31:0] ph, input int mode, input int amp);
    bit [31:0] p;
    int a, v, f;
    p = acc + ph;
    a = int'(p >> 22);
    case (mode)
      0: v = sineRef(a);
      1: v = (a >= 512) ? -32767 : 32767;
      2: begin
        f = (a < 512) ? a : 1023 - a;
        v = f * 128 - 32768;
      end
      default: v = a * 64 - 32768;
    endcase
    return (v * (amp + 1)) >>> 8;
  endfunction

  task automatic modelEdge(input int i);
    bit [31:0] step;
    longint    sum;
    int        modVal;
    bit        wrapEv, hs;
    if (sys_rst) begin
      mAcc[i] = '0; mFreq[i] = 32'd21474836; mPhase[i] = '0; mMode[i] = 0; mAmp[i] = 255;
      mShFreq[i] = mFreq[i]; mShPhase[i] = '0; mShMode[i] = 0; mShAmp[i] = 255;
      mPending[i] = 1'b0; mWrap[i] = 1'b0; mFill[i] = 0;
      return;
    end
    mPipe[i][0] = mPipe[i][1];
    mPipe[i][1] = mPipe[i][2];
    mPipe[i][2] = sampleOf(mAcc[i], mPhase[i], mMode[i], mAmp[i]);
    if (mFill[i] < 3) mFill[i]++;
    modVal = mod_en ? int'(mod_in) * 256 : 0;
    step   = mFreq[i] + 32'(modVal);
    sum    = longint'(mAcc[i]) + longint'(step);
    wrapEv = (sum >= TWO32) || sync_in;
    hs     = cfg_valid && !mPending[i];
    if (mPending[i] && wrapEv) begin
      mFreq[i] = mShFreq[i]; mPhase[i] = mShPhase[i]; mMode[i] = mShMode[i]; mAmp[i] = mShAmp[i];
      mPending[i] = 1'b0;
    end
    if (hs) begin
      mShFreq[i] = cfg_freq; mShPhase[i] = cfg_phase; mShMode[i] = int'(cfg_mode); mShAmp[i] = int'(cfg_amp);
      if (i == 0) begin
        mFreq[i] = cfg_freq; mPhase[i] = cfg_phase; mMode[i] = int'(cfg_mode); mAmp[i] = int'(cfg_amp);
      end else begin
        mPending[i] = 1'b1;
      end
    end
    mAcc[i]  = sync_in ? 32'd0 : 32'(sum);
    mWrap[i] = wrapEv;
  endtask

  task automatic applyStimulus();
    @(posedge sys_clk);
    cycle++;
    for (int i = 0; i < 2; i++) modelEdge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("ready%0d_c%0d", i, cycle), int'(cfgReady[i]), int'(!mPending[i]));
      checkOutput($sformatf("wrap%0d_c%0d", i, cycle), int'(wrapPulse[i]), int'(mWrap[i]));
      checkOutput($sformatf("valid%0d_c%0d", i, cycle), int'(outValid[i]), int'(mFill[i] == 3));
      if (mFill[i] == 3)
        checkOutput($sformatf("wave%0d_c%0d", i, cycle), int'(waveOut[i]), mPipe[i][0]);
      else if (sys_rst)
        checkOutput($sformatf("waveRst%0d_c%0d", i, cycle), int'(waveOut[i]), 0);
    end
  endtask

  task automatic sendConfig(input bit [31:0] f, input bit [31:0] p, input int m, input int a);
    cfg_freq  = f;
    cfg_phase = p;
    cfg_mode  = 2'(m);
    cfg_amp   = 8'(a);
    cfg_valid = 1'b1;
    applyStimulus();
    cfg_valid = 1'b0;
  endtask

  initial begin
    repeat (3) applyStimulus();
    sys_rst = 1'b0;
    repeat (450) applyStimulus();

    sendConfig(32'h4000_0000, 32'd0, 1, 255);
    repeat (300) applyStimulus();

    sendConfig(32'h0040_0000, 32'd0, 3, 255);
    repeat (1100) applyStimulus();

    sendConfig(32'h1000_0000, 32'd0, 1, 127);
    repeat (5) applyStimulus();
    sync_in = 1'b1;
    applyStimulus();
    sync_in = 1'b0;
    repeat (40) applyStimulus();

    sendConfig(32'h0080_0000, $urandom, 2, 200);
    repeat (600) applyStimulus();

    mod_en = 1'b1;
    mod_in = -16'sd1;
    sendConfig(32'h0040_0000, 32'd0, 3, 255);
    repeat (600) applyStimulus();
    repeat (200) begin
      mod_in = 16'($urandom);
      applyStimulus();
    end

    mod_en = 1'b0;
    sendConfig(32'h0010_0000, 32'd0, 1, 255);
    repeat (3) applyStimulus();
    sys_rst = 1'b1;
    applyStimulus();
    sys_rst = 1'b0;
    repeat (20) applyStimulus();

    repeat (1500) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_freq  = $urandom;
      cfg_phase = $urandom;
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_amp   = 8'($urandom_range(0, 255));
      mod_en    = 1'($urandom_range(0, 1));
      mod_in    = 16'($urandom);
      sync_in   = ($urandom_range(0, 31) == 0);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
